// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, encodings and decode helper for alu_sequencer
package alu_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NREGS_DEF  = 8;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] lo;
  } instr_t;

  // LDI reuses the rs field as the immediate high nibble, so it skips the rs check.
  function automatic logic instr_illegal(input logic [3:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs, input int nregs);
    if (op > OP_SHR) return 1'b1;
    if (op == OP_NOP) return 1'b0;
    if (int'(rd) >= nregs) return 1'b1;
    if (op <= OP_MOV && int'(rs) >= nregs) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/alu16.sv
// rtl/alu16.sv - combinational ALU: a is the destination operand, b the source
module alu16
  import alu_seq_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [7:0]   imm,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit W of the widened difference is the unsigned borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin result = sum[W-1:0];  carry = sum[W];  end
      OP_SUB: begin result = diff[W-1:0]; carry = diff[W]; end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = b;
      OP_LDI: result = W'(imm);
      OP_SHL: begin result = {a[W-2:0], 1'b0}; carry = a[W-1]; end
      OP_SHR: begin result = {1'b0, a[W-1:1]}; carry = a[0];   end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-cycle single-issue execute controller for an 8x16 register file
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] Addr_A,
  output logic [ADDR_W-1:0] Addr_B,
  output logic              WR,
  output logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] Src,
  input  logic [DATA_W-1:0] Dest,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

  logic [1:0]        state;
  instr_t            ir;
  logic              illegal;
  logic              writes;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              carry_q;

  assign instr_ready = (state == ST_IDLE);
  assign illegal     = instr_illegal(ir.op, ir.rd, ir.rs, NREGS);
  assign writes      = !illegal && (ir.op != OP_NOP);

  alu16 #(.W(DATA_W)) u_alu (
    .op     (ir.op),
    .a      (Dest),
    .b      (Src),
    .imm    ({ir.rs, ir.lo}),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= ST_IDLE;
      ir      <= '0;
      Addr_A  <= '0;
      Addr_B  <= '0;
      WR      <= 1'b0;
      Data_in <= '0;
      carry_q <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir     <= instr_t'(instr);
            Addr_A <= ADDR_W'(instr[RS_MSB:RS_LSB]);
            Addr_B <= ADDR_W'(instr[RD_MSB:RD_LSB]);
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_EXEC;
        ST_EXEC: begin
          if (writes) begin
            Data_in <= alu_result;
            carry_q <= alu_carry;
          end
          WR    <= writes;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          // Flags follow the value just written, so illegal ops and NOP leave them alone.
          if (WR) begin
            flag_z <= (Data_in == '0);
            flag_c <= carry_q;
          end
          WR    <= 1'b0;
          done  <= 1'b1;
          err   <= illegal;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a register file model
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  Addr_A;
  logic [3:0]  Addr_B;
  logic        WR;
  logic [15:0] Data_in;
  logic [15:0] Src;
  logic [15:0] Dest;
  logic        done;
  logic        err;
  logic        flag_z;
  logic        flag_c;

  logic [15:0] regs [8];
  logic        bd_we = 1'b0;
  logic [2:0]  bd_addr = 3'd0;
  logic [15:0] bd_data = 16'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_sequencer dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .Addr_A      (Addr_A),
    .Addr_B      (Addr_B),
    .WR          (WR),
    .Data_in     (Data_in),
    .Src         (Src),
    .Dest        (Dest),
    .done        (done),
    .err         (err),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  // Register file with registered reads; out-of-range addresses read as zero.
  always @(posedge CLK) begin
    if (bd_we) regs[bd_addr] <= bd_data;
    else if (WR && Addr_B < 4'd8) regs[Addr_B[2:0]] <= Data_in;
    Src  <= (Addr_A < 4'd8) ? regs[Addr_A[2:0]] : 16'h0;
    Dest <= (Addr_B < 4'd8) ? regs[Addr_B[2:0]] : 16'h0;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge after done.
  task automatic exec(input string tag, input logic [15:0] i, input logic exp_wr,
                      input logic [15:0] exp_d, input logic exp_z, input logic exp_c,
                      input logic exp_err);
    chk({tag, ".ready0"}, 32'(instr_ready), 32'd1);
    instr = i; instr_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    instr_valid = 1'b0;
    chk({tag, ".busy"}, 32'(instr_ready), 32'd0);
    chk({tag, ".addr_a"}, 32'(Addr_A), 32'(i[7:4]));
    chk({tag, ".addr_b"}, 32'(Addr_B), 32'(i[11:8]));
    chk({tag, ".wr_c1"}, 32'(WR), 32'd0);
    @(negedge CLK);
    chk({tag, ".wr_c2"}, 32'(WR), 32'd0);
    @(negedge CLK);
    chk({tag, ".wr_c3"}, 32'(WR), 32'(exp_wr));
    chk({tag, ".done_c3"}, 32'(done), 32'd0);
    if (exp_wr) begin
      chk({tag, ".data"}, 32'(Data_in), 32'(exp_d));
      chk({tag, ".wr_addr"}, 32'(Addr_B), 32'(i[11:8]));
    end
    @(negedge CLK);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".wr_c4"}, 32'(WR), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".z"}, 32'(flag_z), 32'(exp_z));
    chk({tag, ".c"}, 32'(flag_c), 32'(exp_c));
    chk({tag, ".ready4"}, 32'(instr_ready), 32'd1);
  endtask

  logic [15:0] prog   [3];
  logic [15:0] prog_d [3];
  int wr_seen;

  initial begin
    RSTn = 1'b0; instr_valid = 1'b0; instr = 16'h0;
    #1;
    chk("rst.wr", 32'(WR), 32'd0);
    chk("rst.addr", 32'({Addr_A, Addr_B}), 32'd0);
    chk("rst.data", 32'(Data_in), 32'd0);
    chk("rst.flags", 32'({done, err, flag_z, flag_c}), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst.ready", 32'(instr_ready), 32'd1);

    exec("ldi", 16'h7134, 1'b1, 16'h0034, 1'b0, 1'b0, 1'b0);

    poke(3'd1, 16'hFFFF);
    poke(3'd2, 16'h0001);
    exec("add", 16'h1120, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);

    poke(3'd1, 16'h0003);
    poke(3'd2, 16'h0005);
    exec("sub", 16'h2120, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    exec("shr", 16'h9100, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    exec("shl", 16'h8100, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    exec("illop", 16'hC000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    exec("badrd", 16'h1910, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    exec("nop", 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    exec("ldi_hi", 16'h7AF0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Valid held high across a dependent three-instruction stream.
    prog[0] = 16'h7310; prog_d[0] = 16'h0010;
    prog[1] = 16'h1330; prog_d[1] = 16'h0020;
    prog[2] = 16'h6430; prog_d[2] = 16'h0020;
    for (int c = 0; c < 12; c++) begin
      instr = prog[c / 4]; instr_valid = 1'b1;
      chk($sformatf("stream.ready%0d", c), 32'(instr_ready), 32'((c % 4) == 0));
      @(posedge CLK);
      @(negedge CLK);
      if ((c % 4) == 2) begin
        chk($sformatf("stream.wr%0d", c), 32'(WR), 32'd1);
        chk($sformatf("stream.data%0d", c), 32'(Data_in), 32'(prog_d[c / 4]));
      end
      if ((c % 4) == 3) chk($sformatf("stream.done%0d", c), 32'(done), 32'd1);
    end
    instr_valid = 1'b0;
    chk("stream.r4", 32'(regs[4]), 32'h0020);

    // Reset while the instruction is in EXEC.
    poke(3'd5, 16'h1234);
    instr = 16'h7555; instr_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("midrst.outs", 32'({WR, done, err, flag_z, flag_c}), 32'd0);
    chk("midrst.data", 32'(Data_in), 32'd0);
    chk("midrst.addr", 32'({Addr_A, Addr_B}), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    wr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (WR) wr_seen++;
    end
    chk("midrst.nowr", 32'(wr_seen), 32'd0);
    chk("midrst.r5", 32'(regs[5]), 32'h1234);
    exec("post", 16'h7600, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
